// File: rtl/spi_dac_receiver.sv
// SPI DAC target: oversampled bCS/SCK/SDI/bLDAC, word commit on frame close, DAC load on bLDAC.
// Optional SDO readback of the previously committed word when SPI_RX_READBACK_EN is defined.
module spi_dac_receiver #(
    parameter int spi_length  = 16,
    parameter int sync_stages = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bCS,
    input  logic                  SCK,
    input  logic                  SDI,
    input  logic                  bLDAC,
    output logic [spi_length-1:0] input_reg,
    output logic [spi_length-1:0] dac_data,
    output logic                  data_valid,
    output logic                  ldac_pulse,
    output logic                  frame_err,
    output logic                  pending,
    output logic                  busy
`ifdef SPI_RX_READBACK_EN
    ,
    output logic                  SDO
`endif
);
    localparam int CW = $clog2(spi_length + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [sync_stages-1:0] cs_sync, sck_sync, sdi_sync, ldac_sync, prime;
    logic                   cs_q, sck_q, ldac_q, armed;
    logic [CW-1:0]          bit_cnt, cnt_nx;
    logic [spi_length-1:0]  shift_reg, sr_nx;
    logic                   overrun, ovr_nx, commit;

    wire cs_s   = cs_sync[sync_stages-1];
    wire sck_s  = sck_sync[sync_stages-1];
    wire sdi_s  = sdi_sync[sync_stages-1];
    wire ldac_s = ldac_sync[sync_stages-1];

    wire cs_rise   = cs_s & ~cs_q;
    wire cs_fall   = ~cs_s & cs_q & armed;
    wire sck_rise  = sck_s & ~sck_q;
    wire sck_fall  = ~sck_s & sck_q;
    wire ldac_fall = ~ldac_s & ldac_q;
    wire primed    = prime[sync_stages-1];

    // prime marks when the chains hold real pin samples rather than reset values;
    // armed then requires a genuine high bCS before any frame may start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            ldac_sync <= '1;
            sck_sync  <= '0;
            sdi_sync  <= '0;
            prime     <= '0;
            cs_q      <= 1'b1;
            ldac_q    <= 1'b1;
            sck_q     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[sync_stages-2:0], bCS};
            ldac_sync <= {ldac_sync[sync_stages-2:0], bLDAC};
            sck_sync  <= {sck_sync[sync_stages-2:0], SCK};
            sdi_sync  <= {sdi_sync[sync_stages-2:0], SDI};
            prime     <= {prime[sync_stages-2:0], 1'b1};
            cs_q      <= cs_s;
            ldac_q    <= ldac_s;
            sck_q     <= sck_s;
            armed     <= armed | (primed & cs_s);
        end
    end

    // SCK edge is applied first so a coincident bCS rise sees the updated count.
    always_comb begin
        cnt_nx = bit_cnt;
        sr_nx  = shift_reg;
        ovr_nx = overrun;
        if (sck_rise) begin
            sr_nx = {shift_reg[spi_length-2:0], sdi_s};
            if (bit_cnt == CW'(spi_length)) ovr_nx = 1'b1;
            else                            cnt_nx = bit_cnt + 1'b1;
        end
        commit = (state == SHIFT) && cs_rise && (cnt_nx == CW'(spi_length)) && !ovr_nx;
    end

`ifdef SPI_RX_READBACK_EN
    logic [spi_length-1:0] rb_reg;
    assign SDO = busy & rb_reg[spi_length-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            overrun    <= 1'b0;
            input_reg  <= '0;
            dac_data   <= '0;
            data_valid <= 1'b0;
            ldac_pulse <= 1'b0;
            frame_err  <= 1'b0;
            pending    <= 1'b0;
            busy       <= 1'b0;
`ifdef SPI_RX_READBACK_EN
            rb_reg     <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            ldac_pulse <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: if (cs_fall) begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                    overrun   <= 1'b0;
                    state     <= SHIFT;
                    busy      <= 1'b1;
`ifdef SPI_RX_READBACK_EN
                    rb_reg    <= input_reg;
`endif
                end
                SHIFT: begin
                    bit_cnt   <= cnt_nx;
                    shift_reg <= sr_nx;
                    overrun   <= ovr_nx;
`ifdef SPI_RX_READBACK_EN
                    if (sck_fall) rb_reg <= {rb_reg[spi_length-2:0], 1'b0};
`endif
                    if (cs_rise) begin
                        overrun <= 1'b0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        if (commit) begin
                            input_reg  <= sr_nx;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A coincident commit is forwarded straight to the DAC register.
            if (ldac_fall) begin
                dac_data   <= commit ? sr_nx : input_reg;
                ldac_pulse <= 1'b1;
                pending    <= 1'b0;
            end else if (commit) begin
                pending    <= 1'b1;
            end
        end
    end

`ifndef SPI_RX_READBACK_EN
    logic unused_fall;
    assign unused_fall = sck_fall;
`endif
endmodule

// File: tb/tb_spi_dac_receiver.sv
// Directed bench for spi_dac_receiver: framing, LDAC load, error frames, reset recovery.
// Readback of SDO is exercised when SPI_RX_READBACK_EN is defined.
module tb_spi_dac_receiver;
    logic        clk = 0, rst = 1;
    logic        bCS = 1, SCK = 0, SDI = 0, bLDAC = 1;
    logic [15:0] input_reg, dac_data;
    logic        data_valid, ldac_pulse, frame_err, pending, busy;
`ifdef SPI_RX_READBACK_EN
    logic        SDO;
    logic [15:0] rb_word;
`endif

    int n_chk = 0, n_pass = 0;
    int dv_n = 0, ld_n = 0, fe_n = 0, both_n = 0;
    int dv0, ld0, fe0, both0;
    logic busy_seen;

    spi_dac_receiver dut (
        .clk(clk), .rst(rst), .bCS(bCS), .SCK(SCK), .SDI(SDI), .bLDAC(bLDAC),
        .input_reg(input_reg), .dac_data(dac_data), .data_valid(data_valid),
        .ldac_pulse(ldac_pulse), .frame_err(frame_err), .pending(pending), .busy(busy)
`ifdef SPI_RX_READBACK_EN
        , .SDO(SDO)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        dv_n   += int'(data_valid);
        ld_n   += int'(ldac_pulse);
        fe_n   += int'(frame_err);
        both_n += int'(data_valid & ldac_pulse);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        dv0 = dv_n; ld0 = ld_n; fe0 = fe_n; both0 = both_n;
    endtask

    // One bCS frame at SCK = clk/16, MSB first; optional bLDAC fall aligned with bCS rise.
    task automatic frame(input logic [15:0] w, input int nbits, input bit ldac_close);
        bCS = 0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            SDI = (i < 16) ? w[15-i] : 1'b0;
            tick(8);
`ifdef SPI_RX_READBACK_EN
            if (i < 16) rb_word[15-i] = SDO;
`endif
            SCK = 1;
            if (i == 0) busy_seen = busy;
            tick(8);
            SCK = 0;
        end
        tick(8);
        bCS = 1;
        if (ldac_close) bLDAC = 0;
        tick(8);
        bLDAC = 1;
        tick(12);
    endtask

    task automatic ldac();
        bLDAC = 0;
        tick(8);
        bLDAC = 1;
        tick(12);
    endtask

    initial begin
        tick(4);
        chk("rst_input_reg", 32'(input_reg), 32'h0);
        chk("rst_dac_data", 32'(dac_data), 32'h0);
        chk("rst_pulses", {29'd0, data_valid, ldac_pulse, frame_err}, 32'h0);
        chk("rst_pending_busy", {30'd0, pending, busy}, 32'h0);
        rst = 0;
        tick(6);

        mark();
        frame(16'hA5C3, 16, 0);
        chk("f1_busy", 32'(busy_seen), 32'h1);
        chk("f1_dv_count", 32'(dv_n - dv0), 32'd1);
        chk("f1_input_reg", 32'(input_reg), 32'hA5C3);
        chk("f1_pending", 32'(pending), 32'h1);
        chk("f1_dac_data", 32'(dac_data), 32'h0);
        chk("f1_busy_after", 32'(busy), 32'h0);

        mark();
        ldac();
        chk("ld1_count", 32'(ld_n - ld0), 32'd1);
        chk("ld1_dac_data", 32'(dac_data), 32'hA5C3);
        chk("ld1_pending", 32'(pending), 32'h0);
        ldac();
        chk("ld2_count", 32'(ld_n - ld0), 32'd2);
        chk("ld2_dac_data", 32'(dac_data), 32'hA5C3);

        mark();
        frame(16'hFFFF, 15, 0);
        chk("short_ferr", 32'(fe_n - fe0), 32'd1);
        chk("short_input_reg", 32'(input_reg), 32'hA5C3);
        frame(16'h5555, 17, 0);
        chk("over_ferr", 32'(fe_n - fe0), 32'd2);
        chk("over_input_reg", 32'(input_reg), 32'hA5C3);
        chk("err_no_dv", 32'(dv_n - dv0), 32'd0);
        frame(16'h1234, 16, 0);
        chk("f1234_input_reg", 32'(input_reg), 32'h1234);
        chk("f1234_pending", 32'(pending), 32'h1);

        mark();
        frame(16'h00FF, 16, 1);
        chk("sim_both", 32'(both_n - both0), 32'd1);
        chk("sim_dac_data", 32'(dac_data), 32'h00FF);
        chk("sim_input_reg", 32'(input_reg), 32'h00FF);
        chk("sim_pending", 32'(pending), 32'h0);

        // Reset mid-frame with bCS held low throughout.
        mark();
        bCS = 0;
        tick(8);
        SDI = 1;
        for (int i = 0; i < 8; i++) begin
            tick(8); SCK = 1; tick(8); SCK = 0;
        end
        rst = 1;
        tick(3);
        chk("mid_rst_regs", {input_reg, dac_data}, 32'h0);
        chk("mid_rst_flags", {27'd0, data_valid, ldac_pulse, frame_err, pending, busy}, 32'h0);
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            tick(8); SCK = 1; tick(8); SCK = 0;
        end
        tick(4);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_pulses", 32'((dv_n - dv0) + (ld_n - ld0) + (fe_n - fe0)), 32'd0);
        chk("post_rst_input_reg", 32'(input_reg), 32'h0);
        bCS = 1;
        tick(10);
        frame(16'h8001, 16, 0);
        chk("f8001_input_reg", 32'(input_reg), 32'h8001);
        chk("f8001_dv", 32'(dv_n - dv0), 32'd1);

`ifdef SPI_RX_READBACK_EN
        frame(16'hBEEF, 16, 0);
        chk("rb_commit", 32'(input_reg), 32'hBEEF);
        chk("rb_idle_sdo", 32'(SDO), 32'h0);
        frame(16'h0000, 16, 0);
        chk("rb_stream", 32'(rb_word), 32'hBEEF);
        chk("rb_idle_sdo2", 32'(SDO), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
